// File: rtl/sd_pkg.sv
// Shared definitions for the SD command path: command content width and the
// scheduler state encoding (also used for debug taps).
package sd_pkg;

  localparam int unsigned CMD_CONTENT_W = 38;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StIssue     = 3'd1,
    StWaitStart = 3'd2,
    StWaitEnd   = 3'd3,
    StGap       = 3'd4
  } sched_state_e;

endpackage

// File: rtl/sd_cmd_sched_if.sv
// Requester/transmitter-facing signals of the command scheduler. The master
// modport is the scheduler; the slave modport is the requesters plus transmitter.
interface sd_cmd_sched_if #(
  parameter int unsigned NREQ = 4
);
  import sd_pkg::*;

  logic [NREQ-1:0]               req;
  logic [NREQ*CMD_CONTENT_W-1:0] req_cmd;
  logic [NREQ-1:0]               gnt;
  logic [NREQ-1:0]               done;
  logic                          err;
  logic                          send_en;
  logic [CMD_CONTENT_W-1:0]      cmd_content;
  logic                          sending;

  modport master (
    input  req, req_cmd, sending,
    output gnt, done, err, send_en, cmd_content
  );

  modport slave (
    output req, req_cmd, sending,
    input  gnt, done, err, send_en, cmd_content
  );

endinterface

// File: rtl/sd_rr_arb.sv
// Combinational round-robin pick: first requester strictly after last_ptr in
// ascending wrap-around order.
module sd_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last_ptr,
  output logic            any,
  output logic [IdxW-1:0] sel_idx
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  int unsigned       first_off;
  int unsigned       pick;

  always_comb begin
    req_dbl   = {req, req};
    // Bit 0 of req_rot is the requester right after last_ptr.
    req_rot   = NREQ'(req_dbl >> (int'(last_ptr) + 1));
    first_off = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) first_off = j;
    end
    pick = int'(last_ptr) + 1 + first_off;
    if (pick >= NREQ) pick = pick - NREQ;
    any     = |req;
    sel_idx = IdxW'(pick);
  end

endmodule

// File: rtl/sd_cmd_sched.sv
// Round-robin scheduler sharing the SD command transmitter: issues one send
// strobe per grant, tracks the busy flag with a start timeout, then holds an idle gap.
module sd_cmd_sched
  import sd_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned START_TO   = 64
) (
  input logic            sd_clk,
  input logic            reset_n,
  sd_cmd_sched_if.master bus
);

  localparam int unsigned     IdxW    = $clog2(NREQ);
  localparam int unsigned     ToW     = $clog2(START_TO);
  localparam int unsigned     GapW    = $clog2(GAP_CYCLES + 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(START_TO - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES);

  sched_state_e             state_q, state_d;
  logic [IdxW-1:0]          cur_q, cur_d;
  logic [IdxW-1:0]          last_ptr_q, last_ptr_d;
  logic [CMD_CONTENT_W-1:0] cmd_q, cmd_d;
  logic [ToW-1:0]           to_cnt_q, to_cnt_d;
  logic [GapW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0]          done_q, done_d;
  logic                     err_q, err_d;

  logic                     arb_any;
  logic [IdxW-1:0]          arb_idx;
  logic [CMD_CONTENT_W-1:0] slot [NREQ];

  sd_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .any      (arb_any),
    .sel_idx  (arb_idx)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot[i] = bus.req_cmd[i*CMD_CONTENT_W +: CMD_CONTENT_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_ptr_d = last_ptr_q;
    cmd_d      = cmd_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = '0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (arb_any) begin
          cur_d      = arb_idx;
          last_ptr_d = arb_idx;
          cmd_d      = slot[arb_idx];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        to_cnt_d = '0;
        state_d  = StWaitStart;
      end
      StWaitStart: begin
        // A start seen on the terminal count still wins over the timeout.
        if (bus.sending) begin
          state_d = StWaitEnd;
        end else if (to_cnt_q == ToLast) begin
          err_d         = 1'b1;
          done_d[cur_q] = 1'b1;
          gap_cnt_d     = '0;
          state_d       = StGap;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWaitEnd: begin
        if (!bus.sending) begin
          done_d[cur_q] = 1'b1;
          gap_cnt_d     = '0;
          state_d       = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      last_ptr_q <= IdxW'(NREQ - 1);
      cmd_q      <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_ptr_q <= last_ptr_d;
      cmd_q      <= cmd_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (state_q == StIssue || state_q == StWaitStart || state_q == StWaitEnd) begin
      bus.gnt[cur_q] = 1'b1;
    end
  end

  assign bus.send_en     = (state_q == StIssue);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.cmd_content = cmd_q;

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Self-checking bench for sd_cmd_sched: directed transaction table, hand-written
// drop/reset sequences, then randomized traffic against a timestamp-based model.
module tb_sd_cmd_sched;
  import sd_pkg::*;

  localparam int NREQ = 4;
  localparam int GAP  = 8;
  localparam int STO  = 64;
  localparam int W    = CMD_CONTENT_W;

  logic sd_clk;
  logic reset_n;

  sd_cmd_sched_if #(.NREQ(NREQ)) bus ();

  sd_cmd_sched #(
    .NREQ       (NREQ),
    .GAP_CYCLES (GAP),
    .START_TO   (STO)
  ) dut (
    .sd_clk  (sd_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transmitter model: raises sending tx_d cycles after send_en (0 = never), holds tx_l.
  int tx_d = 5, tx_l = 10, tx_cd = 0, tx_cl = 0, tx_cnt = 0, tx_fall = -1;
  bit tx_act = 0;
  int prev_fall = -1;

  typedef struct {
    bit              rst;
    logic [NREQ-1:0] req;
    int              d;
    int              l;
    int              exp_idx;
    bit              exp_err;
  } txn_t;

  txn_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] cmd_of(input int i);
    return {6'h08 + 6'(i), 32'h000001AA + 32'(i * 32'h1111)};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tx_step();
    if (!reset_n) begin
      tx_act      = 0;
      bus.sending = 1'b0;
    end else if (bus.send_en) begin
      tx_act      = 1;
      tx_cnt      = 0;
      tx_cd       = tx_d;
      tx_cl       = tx_l;
      bus.sending = 1'b0;
    end else if (tx_act) begin
      tx_cnt++;
      if (tx_cd > 0 && tx_cnt == tx_cd) bus.sending = 1'b1;
      if (tx_cd > 0 && tx_cnt == tx_cd + tx_cl) begin
        bus.sending = 1'b0;
        tx_act      = 0;
        tx_fall     = cyc;
      end
    end
  endtask

  task automatic tick();
    @(negedge sd_clk);
    cyc++;
    tx_step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0;
    tick();
    tick();
    reset_n   = 1'b1;
    prev_fall = -1;
  endtask

  task automatic run_txn(input txn_t r);
    int c;
    if (r.rst) do_reset();
    bus.req = r.req;
    tx_d    = r.d;
    tx_l    = r.l;
    for (int i = 0; i < 400 && !bus.send_en; i++) tick();
    chk("send_en seen", 64'(bus.send_en), 64'(1));
    if (!bus.send_en) return;
    c = cyc;
    chk("grant", 64'(bus.gnt), 64'(onehot(r.exp_idx)));
    chk("cmd_content", 64'(bus.cmd_content), 64'(cmd_of(r.exp_idx)));
    if (prev_fall >= 0) chk("gap spacing ok", 64'(c - prev_fall >= GAP + 3), 64'(1));
    tick();
    chk("send_en one cycle", 64'(bus.send_en), 64'(0));
    for (int i = 0; i < 400 && bus.done == '0; i++) tick();
    chk("done", 64'(bus.done), 64'(onehot(r.exp_idx)));
    chk("err", 64'(bus.err), 64'(r.exp_err));
    chk("gnt low at done", 64'(bus.gnt), 64'(0));
    if (r.d == 0) begin
      chk("timeout latency", 64'(cyc - c), 64'(STO + 1));
      prev_fall = cyc - 1;
    end else begin
      chk("done latency", 64'(cyc - tx_fall), 64'(1));
      prev_fall = tx_fall;
    end
    tick();
    chk("done one cycle", 64'({bus.done, bus.err}), 64'(0));
  endtask

  // Reference model: transactions as timestamps derived from the timing rules.
  int              m_last, m_cur, m_issue, m_done, m_free;
  bit              m_err;
  logic [W-1:0]    m_cmd;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] model_out(input int t);
    logic [NREQ-1:0] g, d;
    g = (t >= m_issue && t < m_done) ? onehot(m_cur) : '0;
    d = (t == m_done) ? onehot(m_cur) : '0;
    return 64'({g, d, (t == m_done) && m_err, t == m_issue, m_cmd});
  endfunction

  initial begin
    logic [NREQ-1:0]      rq;
    logic [NREQ*W-1:0]    rc;
    logic [63:0]          wd;
    int                   p, sel;
    bit                   seen;

    reset_n     = 1'b0;
    bus.req     = '0;
    bus.sending = 1'b0;
    for (int i = 0; i < NREQ; i++) rc[i*W +: W] = cmd_of(i);
    bus.req_cmd = rc;

    tbl[0]  = '{rst: 0, req: 4'b0001, d: 5,   l: 48, exp_idx: 0, exp_err: 0};
    tbl[1]  = '{rst: 1, req: 4'b1111, d: 3,   l: 10, exp_idx: 0, exp_err: 0};
    tbl[2]  = '{rst: 0, req: 4'b1111, d: 2,   l: 7,  exp_idx: 1, exp_err: 0};
    tbl[3]  = '{rst: 0, req: 4'b1111, d: 1,   l: 3,  exp_idx: 2, exp_err: 0};
    tbl[4]  = '{rst: 0, req: 4'b1111, d: 6,   l: 12, exp_idx: 3, exp_err: 0};
    tbl[5]  = '{rst: 0, req: 4'b1111, d: 4,   l: 5,  exp_idx: 0, exp_err: 0};
    tbl[6]  = '{rst: 0, req: 4'b0010, d: 0,   l: 0,  exp_idx: 1, exp_err: 1};
    tbl[7]  = '{rst: 0, req: 4'b0100, d: 2,   l: 6,  exp_idx: 2, exp_err: 0};
    tbl[8]  = '{rst: 0, req: 4'b0101, d: 4,   l: 8,  exp_idx: 0, exp_err: 0};
    tbl[9]  = '{rst: 0, req: 4'b0101, d: 4,   l: 8,  exp_idx: 2, exp_err: 0};
    tbl[10] = '{rst: 0, req: 4'b1000, d: STO, l: 5,  exp_idx: 3, exp_err: 0};

    tick();
    tick();
    chk("reset outputs", 64'({bus.gnt, bus.done, bus.err, bus.send_en, bus.cmd_content}), 64'(0));
    reset_n = 1'b1;

    for (int k = 0; k < 11; k++) run_txn(tbl[k]);

    // Requester 2 drops req while its command is on the line.
    bus.req = 4'b0100;
    tx_d    = 3;
    tx_l    = 20;
    for (int i = 0; i < 400 && !bus.send_en; i++) tick();
    chk("drop: grant", 64'(bus.gnt), 64'(4'b0100));
    for (int i = 0; i < 20 && !bus.sending; i++) tick();
    repeat (4) tick();
    bus.req = '0;
    for (int i = 0; i < 100 && bus.done == '0; i++) tick();
    chk("drop: done", 64'(bus.done), 64'(4'b0100));
    seen = 0;
    repeat (GAP + 10) begin
      tick();
      if (bus.send_en || bus.gnt != '0) seen = 1;
    end
    chk("drop: no regrant", 64'(seen), 64'(0));

    // Reset during WAIT_END of requester 0, then requester 0 must win again.
    bus.req = 4'b0001;
    tx_d    = 3;
    tx_l    = 30;
    for (int i = 0; i < 400 && !bus.send_en; i++) tick();
    chk("rst: grant", 64'(bus.gnt), 64'(4'b0001));
    for (int i = 0; i < 20 && !bus.sending; i++) tick();
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("rst: outputs cleared",
        64'({bus.gnt, bus.done, bus.err, bus.send_en, bus.cmd_content}), 64'(0));
    reset_n = 1'b1;
    bus.req = '0;
    repeat (3) begin
      tick();
      chk("rst: no done", 64'({bus.done, bus.gnt}), 64'(0));
    end
    prev_fall = -1;
    run_txn('{rst: 0, req: 4'b0011, d: 3, l: 5, exp_idx: 0, exp_err: 0});

    // Randomized traffic against the model.
    do_reset();
    m_last  = NREQ - 1;
    m_cur   = 0;
    m_issue = -1000;
    m_done  = -1000;
    m_free  = cyc;
    m_err   = 0;
    m_cmd   = '0;
    for (int n = 0; n < 3000 && n_fail < 50; n++) begin
      chk("model cycle",
          64'({bus.gnt, bus.done, bus.err, bus.send_en, bus.cmd_content}), model_out(cyc));
      rq = bus.req;
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i]) begin
          if ((bus.done[i] && $urandom_range(0, 1) == 0) || $urandom_range(0, 31) == 0)
            rq[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
        end
        wd = {$urandom(), $urandom()};
        rc[i*W +: W] = wd[W-1:0];
      end
      bus.req     = rq;
      bus.req_cmd = rc;
      if (cyc >= m_free && rq != '0) begin
        sel = pick(rq, m_last);
        p   = $urandom_range(0, 9);
        tx_d = (p == 0) ? 0 : (p == 1) ? STO : int'($urandom_range(1, 12));
        tx_l = int'($urandom_range(1, 16));
        m_cur   = sel;
        m_last  = sel;
        m_cmd   = rc[sel*W +: W];
        m_issue = cyc + 1;
        m_err   = (tx_d == 0);
        m_done  = m_err ? m_issue + STO + 1 : m_issue + tx_d + tx_l + 1;
        m_free  = m_done + GAP + 1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
